// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state type for the round-robin bus arbiter.
// Define ARB_PARK_EN to park the bus on the last owner while idle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ARB_IDLE
`define ARB_IDLE 2'd0
`define ARB_GRANT 2'd1
`define ARB_HANDOVER 2'd2
`endif
`ifndef ARB_MAX_HOLD
`define ARB_MAX_HOLD 8
`endif
`ifndef NUM_ARB_TEST
`define NUM_ARB_TEST 2000
`define ARB_LOWER_BOUND 0
`define ARB_UPPER_BOUND 65535
`endif

package bus_arbiter_pkg;

  localparam int DATA_W = `DATA_WIDTH;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE     = `ARB_IDLE,
    S_GRANT    = `ARB_GRANT,
    S_HANDOVER = `ARB_HANDOVER
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan farthest-first so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux2.sv
// Generic 2:1 multiplexer cell used to build the bus data select tree.
module mux2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared data bus with a per-grant hold limit.
// Optional ARB_PARK_EN: park on the last owner, 0-cycle re-grant.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = `ARB_MAX_HOLD
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*DATA_W-1:0] Data_In,
  output logic [NUM_REQ-1:0]        Gnt,
  output logic [SEL_W-1:0]          Sel,
  output logic                      Bus_Valid,
  output logic [DATA_W-1:0]         Bus_Out
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(MAX_HOLD);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               found;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   nxt_ptr;
  logic               show;
  logic [DATA_W-1:0]  node [2*NUM_REQ-1];

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req  (Req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (win)
  );

  assign nxt_ptr = sel_q + SEL_W'(1);

`ifdef ARB_PARK_EN
  logic park_q, park_d;
  logic park_hit;

  assign park_hit = (state_q == S_IDLE) & park_q & Req[sel_q];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
`ifdef ARB_PARK_EN
    park_d  = park_q;
`endif
    unique case (state_q)
      S_IDLE, S_HANDOVER: begin
        gnt_d   = '0;
        state_d = S_IDLE;
`ifdef ARB_PARK_EN
        // Park-hit cycle is already the first cycle of the grant.
        if (park_hit) begin
          if (HOLD == CNT_W'(1)) begin
            ptr_d   = nxt_ptr;
            cnt_d   = '0;
            state_d = S_HANDOVER;
          end else begin
            gnt_d   = NUM_REQ'(1) << sel_q;
            cnt_d   = CNT_W'(2);
            state_d = S_GRANT;
          end
        end else
`endif
        if (found) begin
          gnt_d   = NUM_REQ'(1) << win;
          sel_d   = win;
          cnt_d   = CNT_W'(1);
          state_d = S_GRANT;
`ifdef ARB_PARK_EN
          park_d  = 1'b1;
`endif
        end
      end
      S_GRANT: begin
        if (!Req[sel_q]) begin
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q >= HOLD) begin
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          cnt_d   = '0;
          state_d = S_HANDOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_PARK_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      park_q <= 1'b0;
    end else begin
      park_q <= park_d;
    end
  end

  assign Gnt       = gnt_q | (park_hit ? NUM_REQ'(1) << sel_q : '0);
  assign Bus_Valid = (|gnt_q) | park_hit;
  assign show      = Bus_Valid | ((state_q == S_IDLE) & park_q);
`else
  assign Gnt       = gnt_q;
  assign Bus_Valid = |gnt_q;
  assign show      = Bus_Valid;
`endif

  assign Sel = sel_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_leaf
    assign node[NUM_REQ-1+i] = Data_In[i*DATA_W +: DATA_W];
  end

  // Heap-ordered tree: root is node 0, level d steers on Sel MSB-first.
  for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
    for (genvar j = 0; j < (1 << d); j++) begin : g_mux
      localparam int K = (1 << d) - 1 + j;
      mux2 #(
        .W(DATA_W)
      ) u_mux (
        .a(node[2*K+1]),
        .b(node[2*K+2]),
        .s(sel_q[SEL_W-1-d]),
        .y(node[K])
      );
    end
  end

  assign Bus_Out = show ? node[0] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter (default build).
// Expected values come from an owner/pointer reference model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int MAXH = `ARB_MAX_HOLD;
  localparam int DW   = DATA_W;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] din;
  logic [N-1:0]    gnt;
  logic [SW-1:0]   sel;
  logic            bvalid;
  logic [DW-1:0]   bout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current owner (-1 none), cycles held, next priority.
  int owner    = -1;
  int held     = 0;
  int rr       = 0;
  int last_sel = 0;

  logic [N-1:0] prev_gnt = '0;
  int run = 0;

  bus_arbiter #(
    .NUM_REQ (N),
    .SEL_W   (SW),
    .MAX_HOLD(MAXH)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Req      (req),
    .Data_In  (din),
    .Gnt      (gnt),
    .Sel      (sel),
    .Bus_Valid(bvalid),
    .Bus_Out  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    return (owner >= 0) ? (N'(1) << owner) : '0;
  endfunction

  task automatic model_reset();
    owner    = -1;
    held     = 0;
    rr       = 0;
    last_sel = 0;
    prev_gnt = '0;
    run      = 0;
  endtask

  // One clock edge of the arbitration rules, given Req before the edge.
  task automatic model_step(input logic [N-1:0] r);
    if (owner >= 0) begin
      if (!r[owner] || held >= MAXH) begin
        rr    = (owner + 1) % N;
        owner = -1;
        held  = 0;
      end else begin
        held++;
      end
    end else if (r != '0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (owner < 0 && r[i]) begin
          owner    = i;
          held     = 1;
          last_sel = i;
        end
      end
    end
  endtask

  task automatic compare();
    logic [DW-1:0] eb;
    eb = (owner >= 0) ? din[owner*DW +: DW] : '0;
    check("gnt", gnt, exp_gnt());
    check("valid", bvalid, owner >= 0);
    check("sel", sel, last_sel);
    check("bus", bout, eb);
    check("onehot", $onehot0(gnt), 1);
    if (gnt != '0 && gnt == prev_gnt) run++;
    else if (gnt != '0) run = 1;
    else run = 0;
    prev_gnt = gnt;
    if (gnt != '0) check("hold_max", run <= MAXH, 1);
  endtask

  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++)
      din[i*DW +: DW] = DW'($urandom_range(`ARB_UPPER_BOUND,
                                           `ARB_LOWER_BOUND));
  endtask

  initial begin
    int c0, c1, cz;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r;

    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    rand_data();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", bvalid, 0);
    check("rst_bus", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle('0);

    // Constant contention on 0 and 1: hold limit plus handover gap.
    c0 = 0; c1 = 0; cz = 0;
    for (int k = 0; k < 19; k++) begin
      cycle(4'b0011);
      if (gnt == 4'b0001) c0++;
      else if (gnt == 4'b0010) c1++;
      else cz++;
    end
    check("hold_r0", c0, MAXH + 1);
    check("hold_r1", c1, MAXH);
    check("hold_gap", cz, 2);
    repeat (2) cycle('0);

    // Async reset during the 3rd cycle of a grant to requester 1.
    repeat (3) cycle(4'b0010);
    check("pre_rst_gnt", gnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_sel", sel, 0);
    check("arst_valid", bvalid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0010);
    check("rst_regrant", gnt, 4'b0010);
    cycle('0);

    // Fairness: everyone requests, each drops right after its grant.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(4'b1111 & ~exp_gnt());
      if (gnt != '0 && order.size() < 5)
        order.push_back(int'(sel));
    end
    check("fair_n", order.size(), 5);
    foreach (order[k])
      check("fair_order", order[k], exp_order[k]);
    repeat (2) cycle('0);

    // Single requester 2 with a known data word, then pointer moves to 3.
    din[2*DW +: DW] = DW'(16'h00A5);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0100);
      check("single_gnt", gnt, 4'b0100);
      check("single_bus", bout, 16'h00A5);
    end
    cycle('0);
    check("single_drop", gnt, 0);
    cycle(4'b1011);
    check("ptr3", gnt, 4'b1000);
    repeat (2) cycle('0);

    // Randomized traffic with persistent, occasionally toggling requests.
    r = '0;
    for (int k = 0; k < `NUM_ARB_TEST; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      if ($urandom_range(15) == 0) r = '1;
      rand_data();
      cycle(r);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
